vend_ctrl_multi: RTL

//  Parametrised multi-item vending controller; replaces the per-item fixed-price FSMs.

---
 rtl/vend_pkg.sv | 10 +
 rtl/vend_change_out.sv | 26 ++
 rtl/vend_ctrl_multi.sv | 100 ++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin values and price-table lookup for the vending controller.
package vend_pkg;
   typedef enum logic [2:0] {IDLE, CREDIT, VEND, CHANGE, REFUND} state_t;
   localparam int NICKEL_V = 1;
   localparam int DIME_V = 2;
   localparam int QUARTER_V = 5;
   function automatic int price_at(input logic [63:0] tbl, input int w, input int idx);
      return int'((tbl >> (idx * w)) & ((64'd1 << w) - 64'd1));
   endfunction
endpackage

// File: rtl/vend_change_out.sv
// vend_change_out: emits one nickel_out pulse per loaded nickel, back to back, first pulse on load.
module vend_change_out #(
   parameter int W = 4
)(
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] count_in,
   output logic         nickel_out,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
         nickel_out <= 1'b0;
      end else if (load) begin
         cnt <= count_in - W'(1);
         nickel_out <= 1'b1;
      end else begin
         cnt <= cnt - W'(cnt != '0);
         nickel_out <= cnt != '0;
      end
   end
   assign done = cnt == '0;
endmodule

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-item vending controller with credit accumulation, change and refund.
module vend_ctrl_multi
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS = 3,
   parameter int PRICE_W = 4,
   parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICE_TABLE = {4'd6, 4'd5, 4'd4},
   parameter int MAX_CREDIT = 15,
   localparam int CREDIT_W = $clog2(MAX_CREDIT + 1),
   localparam int SEL_W = $clog2(NUM_ITEMS)
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                nickel_in,
   input  logic                dime_in,
   input  logic                quarter_in,
   input  logic                select_valid,
   input  logic [SEL_W-1:0]    item_sel,
   input  logic                cancel,
   output logic                dispense,
   output logic [SEL_W-1:0]    item_out,
   output logic                nickel_out,
   output logic                coin_reject,
   output logic                sel_error,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);
   localparam int SUM_W = CREDIT_W + 1;
   for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_chk
      if (price_at(64'(PRICE_TABLE), PRICE_W, i) > MAX_CREDIT) begin : g_bad
         $error("PRICE_TABLE entry exceeds MAX_CREDIT");
      end
   end
   state_t state;
   logic [SUM_W-1:0] coin_v, sum;
   logic [CREDIT_W-1:0] price, after_coin, change;
   logic open, refund_go, coin_ok, coin_bad, idx_ok, sel_req, vend_go, sel_bad, load, done;
   assign open = state == IDLE || state == CREDIT;
   assign refund_go = state == CREDIT && cancel;
   assign coin_v = nickel_in ? SUM_W'(NICKEL_V) : dime_in ? SUM_W'(DIME_V) : quarter_in ? SUM_W'(QUARTER_V) : '0;
   assign sum = {1'b0, credit} + coin_v;
   assign coin_ok = open && $onehot({nickel_in, dime_in, quarter_in}) && sum <= SUM_W'(MAX_CREDIT) && !refund_go;
   assign coin_bad = (nickel_in || dime_in || quarter_in) && !coin_ok;
   assign idx_ok = int'(item_sel) < NUM_ITEMS;
   assign price = idx_ok ? CREDIT_W'(price_at(64'(PRICE_TABLE), PRICE_W, int'(item_sel))) : '0;
   // Affordability is judged on the pre-coin credit; a coin accepted alongside simply joins the change.
   assign sel_req = open && select_valid && !refund_go;
   assign vend_go = sel_req && idx_ok && price <= credit;
   assign sel_bad = sel_req && !vend_go;
   assign after_coin = coin_ok ? sum[CREDIT_W-1:0] : credit;
   assign change = after_coin - price;
   assign load = refund_go || (state == VEND && credit != '0);
   vend_change_out #(.W(CREDIT_W)) u_out (
      .clock(clock), .reset(reset), .load(load), .count_in(credit),
      .nickel_out(nickel_out), .done(done)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         credit <= '0;
         dispense <= 1'b0;
         item_out <= '0;
         coin_reject <= 1'b0;
         sel_error <= 1'b0;
         busy <= 1'b0;
      end else begin
         dispense <= vend_go;
         item_out <= vend_go ? item_sel : '0;
         coin_reject <= coin_bad;
         sel_error <= sel_bad;
         case (state)
            IDLE, CREDIT: begin
               if (refund_go) begin
                  state <= REFUND;
                  credit <= credit - CREDIT_W'(1);
                  busy <= 1'b1;
               end else if (vend_go) begin
                  state <= VEND;
                  credit <= change;
                  busy <= 1'b1;
               end else begin
                  state <= after_coin == '0 ? IDLE : CREDIT;
                  credit <= after_coin;
                  busy <= 1'b0;
               end
            end
            VEND: begin
               state <= credit != '0 ? CHANGE : IDLE;
               busy <= credit != '0;
               credit <= credit - CREDIT_W'(credit != '0);
            end
            default: begin
               state <= done ? IDLE : state;
               busy <= !done;
               credit <= credit - CREDIT_W'(credit != '0);
            end
         endcase
      end
   end
endmodule
